// File: rtl/pipe_reg_pkg.sv
// Shared defaults and helpers for the pipe_reg register pipeline.
package pipe_reg_pkg;

    localparam int N_DEF     = 8;
    localparam int DEPTH_DEF = 4;

    // Width needed to hold any valid-stage count from 0 to depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a W-bit data register plus its valid bit.
// Flush clears only the valid bit; the data still follows en.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         en,
    input  logic [W-1:0] d_i,
    input  logic         v_i,
    output logic [W-1:0] d_o,
    output logic         v_o
);

    logic [W-1:0] data_q;
    logic         vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (en) begin
                data_q <= d_i;
            end
            if (flush) begin
                vld_q <= 1'b0;
            end else if (en) begin
                vld_q <= v_i;
            end
        end
    end

    assign d_o = data_q;
    assign v_o = vld_q;

endmodule

// File: rtl/pipe_reg.sv
// DEPTH-stage valid-tagged register pipeline with stall, flush and an occupancy count.
// Define PIPE_REG_QN_EN to add the complemented output qn.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [N-1:0]               d,
    input  logic                       d_valid,
    output logic [N-1:0]               q,
    output logic                       q_valid,
    output logic [cnt_w(DEPTH)-1:0]    count
`ifdef PIPE_REG_QN_EN
    ,
    output logic [N-1:0]               qn
`endif
);

    localparam int CW = cnt_w(DEPTH);

    logic [N-1:0]  data_q [DEPTH];
    logic          vld_q  [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            pipe_stage #(.W(N)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .en    (en),
                .d_i   (d),
                .v_i   (d_valid),
                .d_o   (data_q[i]),
                .v_o   (vld_q[i])
            );
        end else begin : g_body
            pipe_stage #(.W(N)) u_stage (
                .clk   (clk),
                .rst   (rst),
                .flush (flush),
                .en    (en),
                .d_i   (data_q[i-1]),
                .v_i   (vld_q[i-1]),
                .d_o   (data_q[i]),
                .v_o   (vld_q[i])
            );
        end
    end

    // Tracked incrementally rather than by popcount: one item in, one item out per advance.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(d_valid) - CW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_valid = vld_q[DEPTH-1];
    assign count   = count_q;

`ifdef PIPE_REG_QN_EN
    assign qn = ~q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg (N=8, DEPTH=4): directed vector table, then random traffic vs a queue model.
// qn is connected and checked only when PIPE_REG_QN_EN is defined.
module tb_pipe_reg;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  d = '0;
    logic          d_valid = 1'b0;
    logic [N-1:0]  q;
    logic          q_valid;
    logic [CW-1:0] count;
`ifdef PIPE_REG_QN_EN
    logic [N-1:0]  qn;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pipe_reg #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .count   (count)
`ifdef PIPE_REG_QN_EN
        ,
        .qn      (qn)
`endif
    );

    typedef struct {
        logic         rst;
        logic         en;
        logic         flush;
        logic         dv;
        logic [7:0]   d;
        logic         chk_q;
        logic [7:0]   exp_q;
        logic         exp_qv;
        int           exp_cnt;
    } vec_t;

    task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
    endtask

    task automatic apply(input logic r, input logic e, input logic f, input logic v, input logic [7:0] dd);
        rst = r; en = e; flush = f; d_valid = v; d = dd;
        @(posedge clk);
        #1;
    endtask

    // Reference: one {valid,data} entry per stage, index 0 is the entry nearest d.
    logic [N:0] model [$];

    function automatic int model_count();
        int c = 0;
        foreach (model[k]) c += int'(model[k][N]);
        return c;
    endfunction

    vec_t vecs [$];

    function automatic vec_t mk(input logic r, e, f, v, input logic [7:0] dd,
                                input logic cq, input logic [7:0] eq, input logic eqv, input int ec);
        vec_t t;
        t.rst = r; t.en = e; t.flush = f; t.dv = v; t.d = dd;
        t.chk_q = cq; t.exp_q = eq; t.exp_qv = eqv; t.exp_cnt = ec;
        return t;
    endfunction

    initial begin
        // reset held two edges with active-looking inputs
        vecs.push_back(mk(1,1,0,1,8'hAA, 1,8'h00,0,0));
        vecs.push_back(mk(1,1,0,1,8'hAA, 1,8'h00,0,0));
        // stream 11..44, then a bubble
        vecs.push_back(mk(0,1,0,1,8'h11, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,1,8'h22, 0,8'h00,0,2));
        vecs.push_back(mk(0,1,0,1,8'h33, 0,8'h00,0,3));
        vecs.push_back(mk(0,1,0,1,8'h44, 1,8'h11,1,4));
        vecs.push_back(mk(0,1,0,0,8'h00, 1,8'h22,1,3));
        // refill to full
        vecs.push_back(mk(0,1,0,1,8'h55, 1,8'h33,1,3));
        vecs.push_back(mk(0,1,0,1,8'h66, 1,8'h44,1,3));
        vecs.push_back(mk(0,1,0,1,8'h77, 0,8'h00,0,3));
        vecs.push_back(mk(0,1,0,1,8'h88, 1,8'h55,1,4));
        // stall three edges while d changes, then resume
        vecs.push_back(mk(0,0,0,1,8'h99, 1,8'h55,1,4));
        vecs.push_back(mk(0,0,0,1,8'hAB, 1,8'h55,1,4));
        vecs.push_back(mk(0,0,0,1,8'hCD, 1,8'h55,1,4));
        vecs.push_back(mk(0,1,0,1,8'hE1, 1,8'h66,1,4));
        // flush with a valid item offered, then four empty edges
        vecs.push_back(mk(0,1,1,1,8'h55, 0,8'h00,0,0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(0,1,0,0,8'h00, 0,8'h00,0,0));
        // bubbles 1,0,1 then drain
        vecs.push_back(mk(0,1,0,1,8'hA1, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,1,8'hA3, 0,8'h00,0,2));
        vecs.push_back(mk(0,1,0,0,8'h00, 1,8'hA1,1,2));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 1,8'hA3,1,1));
        // build count=3, then reset mid-stream
        vecs.push_back(mk(0,1,0,1,8'hB1, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,1,8'hB2, 0,8'h00,0,2));
        vecs.push_back(mk(0,1,0,1,8'hB3, 0,8'h00,0,3));
        vecs.push_back(mk(1,1,0,1,8'hC0, 1,8'h00,0,0));
        // first item after reset emerges DEPTH edges later
        vecs.push_back(mk(0,1,0,1,8'hC1, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 1,8'hC1,1,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,8'h00,0,0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].dv, vecs[i].d);
            chk("q_valid", i, 32'(q_valid), 32'(vecs[i].exp_qv));
            chk("count", i, 32'(count), 32'(vecs[i].exp_cnt));
            if (vecs[i].chk_q) chk("q", i, 32'(q), 32'(vecs[i].exp_q));
`ifdef PIPE_REG_QN_EN
            chk("qn", i, 32'(qn), 32'(~q));
            if (vecs[i].rst) chk("qn_rst", i, 32'(qn), 32'hFF);
`endif
        end

        // random traffic; start from a known reset state
        apply(1, 0, 0, 0, 8'h00);
        model.delete();
        for (int k = 0; k < DEPTH; k++) model.push_back('0);
        for (int s = 0; s < 400; s++) begin
            logic r, e, f, v;
            logic [7:0] dd;
            logic [N:0] tail;
            r  = ($urandom_range(0, 39) == 0);
            f  = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 3) != 0);
            v  = $urandom_range(0, 1);
            dd = 8'($urandom);
            apply(r, e, f, v, dd);
            if (r) begin
                foreach (model[k]) model[k] = '0;
            end else begin
                if (e) begin
                    model.push_front({v & ~f, dd});
                    void'(model.pop_back());
                end
                if (f) foreach (model[k]) model[k][N] = 1'b0;
            end
            tail = model[DEPTH-1];
            chk("rnd_q_valid", s, 32'(q_valid), 32'(tail[N]));
            chk("rnd_count", s, 32'(count), 32'(model_count()));
            if (tail[N] || r) chk("rnd_q", s, 32'(q), 32'(tail[N-1:0]));
`ifdef PIPE_REG_QN_EN
            chk("rnd_qn", s, 32'(qn), 32'(~tail[N-1:0] & {N{tail[N] | r}} | ~q & {N{~(tail[N] | r)}}));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
